// File: rtl/ddr_global_pkg.sv
// Shared types and constants for the DDR common block.
package ddr_global_pkg;

  // Number of flops in the comparator synchronizer.
  localparam int DDR_ZQCAL_SYNC_STAGES = 2;

  // ZQ calibration sequencer states.
  typedef enum logic [2:0] {
    ZQ_IDLE   = 3'd0,
    ZQ_SET    = 3'd1,
    ZQ_WAIT   = 3'd2,
    ZQ_SAMPLE = 3'd3,
    ZQ_DONE   = 3'd4
  } ddr_zqcal_state_t;

endpackage

// File: rtl/ddr_zqcal_sync.sv
// Multi-flop synchronizer for the asynchronous analog ZQ comparator output.
module ddr_zqcal_sync
  import ddr_global_pkg::*;
#(
  parameter int STAGES = DDR_ZQCAL_SYNC_STAGES
) (
  input  logic i_hclk,
  input  logic i_hreset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] ff;

  // Shift the raw comparator level through the flop chain.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) ff <= '0;
    else          ff <= {ff[STAGES-2:0], i_d};
  end

  assign o_q = ff[STAGES-1];

endmodule

// File: rtl/ddr_cmn_zqcal_fsm.sv
// ZQ calibration sequencer: SAR search for the pull-up code, then the
// pull-down code, against the synchronized analog ZQ comparator.
module ddr_cmn_zqcal_fsm
  import ddr_global_pkg::*;
#(
  parameter int CODE_W   = 6,
  parameter int SETTLE_W = 8
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_cal_en,
  input  logic                i_start,
  input  logic [SETTLE_W-1:0] i_settle_cyc,
  input  logic                i_cmp,
  output logic                o_cmp_en,
  output logic                o_cmp_sel,
  output logic [CODE_W-1:0]   o_zq_pu_code,
  output logic [CODE_W-1:0]   o_zq_pd_code,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pu_sat,
  output logic                o_pd_sat
);

  localparam int                 BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [BIT_W-1:0]   BIT_MSB = BIT_W'(CODE_W - 1);
  localparam logic [CODE_W-1:0]  MID     = {1'b1, {(CODE_W-1){1'b0}}};
  localparam int                 CNT_W   = SETTLE_W + 1;

  ddr_zqcal_state_t  state;
  logic              phase;     // 0 = pull-up, 1 = pull-down
  logic [BIT_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] pu_code, pd_code;
  logic              done, pu_sat, pd_sat;
  logic              cmp_s;

  logic [CODE_W-1:0] act_code, bit_mask, set_code, smp_code;
  logic              smp_sat;

  ddr_zqcal_sync u_sync (
    .i_hclk   (i_hclk),
    .i_hreset (i_hreset),
    .i_d      (i_cmp),
    .o_q      (cmp_s)
  );

  // Trial/resolve values for the active phase's code at the current bit.
  always_comb begin
    act_code = phase ? pd_code : pu_code;
    bit_mask = CODE_W'(1) << bit_idx;
    set_code = act_code | bit_mask;
    smp_code = cmp_s ? act_code : (act_code & ~bit_mask);
    smp_sat  = (smp_code == '0) || (&smp_code);
  end

  // Sequencer FSM with SAR datapath and settle counter; abort wins over all.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state   <= ZQ_IDLE;
      phase   <= 1'b0;
      bit_idx <= BIT_MSB;
      cnt     <= '0;
      pu_code <= MID;
      pd_code <= MID;
      done    <= 1'b0;
      pu_sat  <= 1'b0;
      pd_sat  <= 1'b0;
    end else if (state != ZQ_IDLE && !i_cal_en) begin
      state <= ZQ_IDLE;
    end else begin
      case (state)
        ZQ_IDLE: begin
          if (i_start && i_cal_en) begin
            state   <= ZQ_SET;
            phase   <= 1'b0;
            bit_idx <= BIT_MSB;
            pu_code <= '0;
            done    <= 1'b0;
            pu_sat  <= 1'b0;
            pd_sat  <= 1'b0;
          end
        end
        ZQ_SET: begin
          if (phase) pd_code <= set_code;
          else       pu_code <= set_code;
          // +2 absorbs the comparator synchronizer latency
          cnt   <= {1'b0, i_settle_cyc} + CNT_W'(2);
          state <= ZQ_WAIT;
        end
        ZQ_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ZQ_SAMPLE;
        end
        ZQ_SAMPLE: begin
          if (phase) pd_code <= smp_code;
          else       pu_code <= smp_code;
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - BIT_W'(1);
            state   <= ZQ_SET;
          end else if (!phase) begin
            pu_sat  <= smp_sat;
            phase   <= 1'b1;
            bit_idx <= BIT_MSB;
            pd_code <= '0;
            state   <= ZQ_SET;
          end else begin
            pd_sat <= smp_sat;
            done   <= 1'b1;
            state  <= ZQ_DONE;
          end
        end
        ZQ_DONE: state <= ZQ_IDLE;
        default: state <= ZQ_IDLE;
      endcase
    end
  end

  assign o_busy       = (state == ZQ_SET) || (state == ZQ_WAIT) || (state == ZQ_SAMPLE);
  assign o_cmp_en     = o_busy;
  assign o_cmp_sel    = phase;
  assign o_zq_pu_code = pu_code;
  assign o_zq_pd_code = pd_code;
  assign o_done       = done;
  assign o_pu_sat     = pu_sat;
  assign o_pd_sat     = pd_sat;

endmodule

// File: tb/tb_ddr_cmn_zqcal_fsm.sv
// Scoreboard bench for the ZQ calibration sequencer with a comparator model.
module tb_ddr_cmn_zqcal_fsm;
  localparam int CODE_W   = 6;
  localparam int SETTLE_W = 8;
  localparam int MAXC     = (1 << CODE_W) - 1;

  logic clk = 1'b0;
  logic rst, en, start;
  logic [SETTLE_W-1:0] settle;
  logic cmp;
  logic cmp_en, cmp_sel, busy, done, pu_sat, pd_sat;
  logic [CODE_W-1:0] pu_code, pd_code;

  always #5 clk = ~clk;

  ddr_cmn_zqcal_fsm #(.CODE_W(CODE_W), .SETTLE_W(SETTLE_W)) dut (
    .i_hclk(clk), .i_hreset(rst), .i_cal_en(en), .i_start(start),
    .i_settle_cyc(settle), .i_cmp(cmp), .o_cmp_en(cmp_en), .o_cmp_sel(cmp_sel),
    .o_zq_pu_code(pu_code), .o_zq_pd_code(pd_code), .o_busy(busy),
    .o_done(done), .o_pu_sat(pu_sat), .o_pd_sat(pd_sat)
  );

  // Comparator model: 0 = keep while code <= target, 1 = always 1, 2 = always 0
  int pu_mode = 0, pd_mode = 0, pu_tgt = 0, pd_tgt = 0;

  function automatic logic cmp_of(int mode, int tgt, logic [CODE_W-1:0] code);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return int'(code) <= tgt;
  endfunction

  assign cmp = cmp_sel ? cmp_of(pd_mode, pd_tgt, pd_code) : cmp_of(pu_mode, pu_tgt, pu_code);

  typedef struct {
    string nm;
    int    busy_len;
    int    done;
    int    pu, pd;
    int    pu_sat, pd_sat;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0;
  int mdl_pu = 1 << (CODE_W-1), mdl_pd = 1 << (CODE_W-1);

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Final code a SAR search reaches under each comparator behaviour.
  function automatic int sar_result(int mode, int tgt);
    if (mode == 1) return MAXC;
    if (mode == 2) return 0;
    return tgt;
  endfunction

  function automatic int is_sat(int c);
    return (c == 0 || c == MAXC) ? 1 : 0;
  endfunction

  // PU code left behind when calibration is aborted during busy cycle a.
  function automatic int abort_pu(int tgt, int s, int a);
    int p, k, b, o, hi;
    p  = s + 4;
    k  = (a - 1) / p;
    b  = CODE_W - 1 - k;
    o  = (a - 1) % p;
    hi = (tgt >> (b + 1)) << (b + 1);
    return hi | ((o != 0) ? (1 << b) : 0);
  endfunction

  // Monitor: measure each busy window and score it when busy falls.
  initial begin
    int blen, cen_bad;
    exp_t e;
    blen = 0;
    cen_bad = 0;
    forever begin
      @(negedge clk);
      if (cmp_en !== busy) cen_bad++;
      if (busy === 1'b1) blen++;
      else if (blen > 0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_run: busy window of %0d cycles with no pending run", blen);
        end else begin
          e = sb.pop_front();
          chk({e.nm, ".busy_len"}, blen, e.busy_len);
          chk({e.nm, ".done"}, int'(done), e.done);
          chk({e.nm, ".pu_code"}, int'(pu_code), e.pu);
          chk({e.nm, ".pd_code"}, int'(pd_code), e.pd);
          chk({e.nm, ".pu_sat"}, int'(pu_sat), e.pu_sat);
          chk({e.nm, ".pd_sat"}, int'(pd_sat), e.pd_sat);
          chk({e.nm, ".cmp_en_track"}, cen_bad, 0);
        end
        blen = 0;
      end
    end
  end

  task automatic run_start(int s);
    @(negedge clk);
    settle = SETTLE_W'(s);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_drain(string nm);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (k == 3000) begin
      checks++; errors++;
      $display("FAIL %s.timeout: run still pending after 3000 cycles", nm);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic push_full(string nm, int s);
    exp_t e;
    e.nm       = nm;
    e.busy_len = 2 * CODE_W * (s + 4);
    e.done     = 1;
    e.pu       = sar_result(pu_mode, pu_tgt);
    e.pd       = sar_result(pd_mode, pd_tgt);
    e.pu_sat   = is_sat(e.pu);
    e.pd_sat   = is_sat(e.pd);
    sb.push_back(e);
    mdl_pu = e.pu;
    mdl_pd = e.pd;
  endtask

  task automatic do_full(string nm, int s);
    push_full(nm, s);
    run_start(s);
    wait_drain(nm);
  endtask

  task automatic do_abort(string nm, int s, int a);
    exp_t e;
    e.nm = nm; e.busy_len = a; e.done = 0;
    e.pu = abort_pu(pu_tgt, s, a); e.pd = mdl_pd;
    e.pu_sat = 0; e.pd_sat = 0;
    sb.push_back(e);
    mdl_pu = e.pu;
    run_start(s);
    repeat (a - 1) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    wait_drain(nm);
    repeat (8) @(negedge clk);
    chk({nm, ".pu_frozen"}, int'(pu_code), mdl_pu);
    chk({nm, ".pd_frozen"}, int'(pd_code), mdl_pd);
  endtask

  task automatic do_reset(string nm, int s, int a);
    exp_t e;
    e.nm = nm; e.busy_len = a; e.done = 0;
    e.pu = 1 << (CODE_W-1); e.pd = 1 << (CODE_W-1);
    e.pu_sat = 0; e.pd_sat = 0;
    sb.push_back(e);
    mdl_pu = e.pu;
    mdl_pd = e.pd;
    run_start(s);
    repeat (a - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({nm, ".cmp_sel"}, int'(cmp_sel), 0);
    wait_drain(nm);
  endtask

  initial begin
    int s, a, cnt;
    rst = 1'b1; en = 1'b0; start = 1'b0; settle = '0;
    repeat (3) @(negedge clk);
    chk("reset.pu_code", int'(pu_code), 32);
    chk("reset.pd_code", int'(pd_code), 32);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.sat", int'({pu_sat, pd_sat}), 0);
    chk("reset.cmp_en_sel", int'({cmp_en, cmp_sel}), 0);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    // nominal run
    pu_mode = 0; pd_mode = 0; pu_tgt = 37; pd_tgt = 12;
    do_full("nominal", 4);
    repeat (5) @(negedge clk);
    chk("nominal.done_sticky", int'(done), 1);

    // start with cal_en low must do nothing
    en = 1'b0;
    run_start(4);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (busy) cnt++; end
    chk("start_en_low.busy_cycles", cnt, 0);
    chk("start_en_low.done_kept", int'(done), 1);
    en = 1'b1;

    // saturation
    pu_mode = 1; pd_mode = 2;
    do_full("saturate", 3);

    // start pulse while busy must not restart
    pu_mode = 0; pd_mode = 0; pu_tgt = 21; pd_tgt = 50;
    push_full("start_busy", 4);
    run_start(4);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("start_busy");

    // zero settle
    pu_tgt = 37; pd_tgt = 12;
    do_full("zero_settle", 0);

    // abort at busy cycle 40, then a clean rerun
    do_abort("abort40", 4, 40);
    do_full("after_abort", 4);

    // reset mid-run
    do_reset("reset_mid", 4, 55);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      s = $urandom_range(0, 10);
      pu_mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      pd_mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      pu_tgt  = $urandom_range(0, MAXC);
      pd_tgt  = $urandom_range(0, MAXC);
      if (pu_mode == 0 && $urandom_range(0, 3) == 0) begin
        a = $urandom_range(1, CODE_W * (s + 4));
        do_abort($sformatf("rand%0d_abort", r), s, a);
      end else if ($urandom_range(0, 7) == 0) begin
        a = $urandom_range(1, 2 * CODE_W * (s + 4));
        do_reset($sformatf("rand%0d_reset", r), s, a);
      end else begin
        do_full($sformatf("rand%0d", r), s);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
